// File: rtl/alu_seq_nbit.sv
// Registered N-bit ALU with a start/ready/done handshake.
// Logic ops and add/sub finish in one clock. Shifts move one bit per clock.
module alu_seq_nbit #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             CarryIn,
  input  logic [3:0]       ALUOp,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       shop_q, shop_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic             accept;
  logic             is_shift;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             complete;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             ovf_c;

  // One-bit step of a shift; kind comes from ALUOp[1:0] (00 SLL, 01 SRL, 10 SRA).
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic [1:0]       kind);
    case (kind)
      2'b00:   shift_one = {v[WIDTH-2:0], 1'b0};
      2'b01:   shift_one = {1'b0, v[WIDTH-1:1]};
      default: shift_one = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  assign accept   = Start && ready_q;
  assign is_shift = (ALUOp == OP_SLL) || (ALUOp == OP_SRL) || (ALUOp == OP_SRA);
  assign shamt    = b[SHW-1:0];

  // Single-cycle datapath; SUB reuses the adder with ~b and a forced carry of 1.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    b_eff     = (ALUOp == OP_SUB) ? ~b : b;
    cin       = (ALUOp == OP_SUB) ? 1'b1 : ((ALUOp == OP_ADD) ? CarryIn : 1'b0);
    sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (ALUOp)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD, OP_SUB: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // Next-state logic. The first shift step happens on the accept edge, so a
  // shift by s spends s-1 cycles in SHIFT.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    shop_d   = shop_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    complete = 1'b0;
    res_c    = '0;
    carry_c  = 1'b0;
    ovf_c    = 1'b0;

    case (state_q)
      SHIFT: begin
        shreg_d = shift_one(shreg_q, shop_q);
        cnt_d   = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          complete = 1'b1;
          res_c    = shift_one(shreg_q, shop_q);
        end
      end
      default: begin
        if (accept) begin
          if (is_shift) begin
            shop_d = ALUOp[1:0];
            if (shamt == '0) begin
              complete = 1'b1;
              res_c    = a;
            end else if (shamt == SHW'(1)) begin
              complete = 1'b1;
              res_c    = shift_one(a, ALUOp[1:0]);
            end else begin
              shreg_d = shift_one(a, ALUOp[1:0]);
              cnt_d   = shamt - SHW'(1);
              state_d = SHIFT;
            end
          end else begin
            complete = 1'b1;
            res_c    = alu_res;
            carry_c  = alu_carry;
            ovf_c    = alu_ovf;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    if (complete) begin
      state_d  = DONE;
      result_d = res_c;
      carry_d  = carry_c;
      ovf_d    = ovf_c;
      zero_d   = (res_c == '0);
    end

    ready_d = (state_d != SHIFT);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      shop_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      shop_q   <= shop_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign Ready    = ready_q;
  assign Done     = done_q;
  assign Result   = result_q;
  assign CarryOut = carry_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;

endmodule
